// File: rtl/complex_magnitude_stream.sv
// complex_magnitude_stream: pipelined alpha*max+beta*min |I+jQ| estimator with block peak/exponent tracking
module complex_magnitude_stream #(
   parameter int WIDTH     = 16,
   parameter bit IS_SIGNED = 1'b1,
   parameter int BLOCK_LEN = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH-1:0]         s_i,
   input  logic [WIDTH-1:0]         s_q,
   input  logic [1:0]               s_mode,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_mag,
   output logic                     m_last,
   output logic                     peak_valid,
   output logic [WIDTH-1:0]         peak_mag,
   output logic [$clog2(WIDTH)-1:0] peak_exp
);
   localparam int EW = $clog2(WIDTH);
   localparam int CW = $clog2(BLOCK_LEN);
   logic             en, hs;
   logic             v1, v2;
   logic [WIDTH-1:0] a1, b1, mx2, mn2, mag_next, run_pk, pk_next;
   logic [1:0]       md1, md2;
   logic [WIDTH:0]   mx_e, mn_e, alt, sum;
   logic [CW-1:0]    cnt;
   logic [EW-1:0]    lead;
   assign en      = !m_valid || m_ready;
   assign s_ready = en;
   assign hs      = m_valid && m_ready;
   assign m_last  = m_valid && (cnt == CW'(BLOCK_LEN - 1));
   // Unsigned WIDTH-bit result makes -2^(WIDTH-1) come out as +2^(WIDTH-1)
   function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] x);
      return (IS_SIGNED && x[WIDTH-1]) ? -x : x;
   endfunction
   always_comb begin
      mx_e     = {1'b0, mx2};
      mn_e     = {1'b0, mn2};
      alt      = mx_e - (mx_e >> 3) + (mn_e >> 1);
      sum      = (md2 == 2'd0) ? mx_e + (mn_e >> 1) :
                 (md2 == 2'd1) ? mx_e + (mn_e >> 2) :
                 (md2 == 2'd2) ? ((alt > mx_e) ? alt : mx_e) : mx_e;
      mag_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         m_valid <= 1'b0;
      end else if (en) begin
         v1      <= s_valid;
         v2      <= v1;
         m_valid <= v2;
      end
   end
   // Data stages carry no reset; their valids gate everything downstream
   always_ff @(posedge clk) begin
      if (en) begin
         a1    <= abs_f(s_i);
         b1    <= abs_f(s_q);
         md1   <= s_mode;
         mx2   <= (a1 > b1) ? a1 : b1;
         mn2   <= (a1 > b1) ? b1 : a1;
         md2   <= md1;
         m_mag <= mag_next;
      end
   end
   assign pk_next = (m_mag > run_pk) ? m_mag : run_pk;
   always_comb begin
      lead = '0;
      for (int k = 0; k < WIDTH; k++)
         if (pk_next[k]) lead = EW'(k);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         run_pk     <= '0;
         peak_valid <= 1'b0;
         peak_mag   <= '0;
         peak_exp   <= '0;
      end else begin
         peak_valid <= hs && m_last;
         if (hs && m_last) begin
            cnt      <= '0;
            run_pk   <= '0;
            peak_mag <= pk_next;
            peak_exp <= lead;
         end else if (hs) begin
            cnt    <= cnt + 1'b1;
            run_pk <= pk_next;
         end
      end
   end
endmodule
